// File: rtl/sc_game_sequencer.sv
// Game-flow controller for the Frogger datapath: respawn/load sequencing, run gating,
// lives and level tracking, and the game-over / win indications.
module sc_game_sequencer #(
    parameter int LIVES_INIT  = 3,
    parameter int LIVES_WIDTH = 2,
    parameter int LEVEL_WIDTH = 2,
    parameter int MAX_LEVEL   = 3,
    parameter int HOLD_TICKS  = 4,
    parameter int HOLD_WIDTH  = 3
) (
    input  logic                   SC_GAMESEQ_CLOCK_50,
    input  logic                   SC_GAMESEQ_RESET_InLow,
    input  logic                   SC_GAMESEQ_start_InLow,
    input  logic                   SC_GAMESEQ_tick_In,
    input  logic                   SC_GAMESEQ_crash_In,
    input  logic                   SC_GAMESEQ_goal_In,
    output logic                   SC_GAMESEQ_load_Out,
    output logic                   SC_GAMESEQ_run_Out,
    output logic [LIVES_WIDTH-1:0] SC_GAMESEQ_lives_OutBUS,
    output logic [LEVEL_WIDTH-1:0] SC_GAMESEQ_level_OutBUS,
    output logic                   SC_GAMESEQ_gameover_Out,
    output logic                   SC_GAMESEQ_win_Out,
    output logic [2:0]             SC_GAMESEQ_state_OutBUS
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SPAWN = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_CRASH = 3'd3;
    localparam logic [2:0] S_NEXT  = 3'd4;
    localparam logic [2:0] S_LOSE  = 3'd5;
    localparam logic [2:0] S_WIN   = 3'd6;

    localparam logic [LIVES_WIDTH-1:0] LIVES_RST = LIVES_WIDTH'(LIVES_INIT);
    localparam logic [LEVEL_WIDTH-1:0] LEVEL_MAX = LEVEL_WIDTH'(MAX_LEVEL);
    localparam logic [HOLD_WIDTH-1:0]  HOLD_END  = HOLD_WIDTH'(HOLD_TICKS);

    logic [2:0]             state_q, state_d;
    logic [LIVES_WIDTH-1:0] lives_q, lives_d;
    logic [LEVEL_WIDTH-1:0] level_q, level_d;
    logic [HOLD_WIDTH-1:0]  hold_q, hold_d;
    logic                   start_prev_q;
    logic                   start_press;
    logic [HOLD_WIDTH-1:0]  hold_inc;

    // Falling edge of the active-low button; a held button yields one press.
    assign start_press = start_prev_q & ~SC_GAMESEQ_start_InLow;
    assign hold_inc    = hold_q + 1'b1;

    always_ff @(posedge SC_GAMESEQ_CLOCK_50) begin
        if (!SC_GAMESEQ_RESET_InLow) begin
            state_q      <= S_IDLE;
            lives_q      <= LIVES_RST;
            level_q      <= '0;
            hold_q       <= '0;
            start_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            level_q      <= level_d;
            hold_q       <= hold_d;
            start_prev_q <= SC_GAMESEQ_start_InLow;
        end
    end

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        level_d = level_q;
        hold_d  = hold_q;
        case (state_q)
            S_IDLE: begin
                lives_d = LIVES_RST;
                level_d = '0;
                if (start_press) state_d = S_SPAWN;
            end
            S_SPAWN: begin
                hold_d  = '0;
                state_d = S_PLAY;
            end
            S_PLAY: begin
                // Comparator outputs are only trusted on the game-step tick.
                if (SC_GAMESEQ_tick_In) begin
                    if (SC_GAMESEQ_crash_In) begin
                        state_d = S_CRASH;
                        lives_d = (lives_q == '0) ? '0 : lives_q - 1'b1;
                    end else if (SC_GAMESEQ_goal_In) begin
                        state_d = S_NEXT;
                    end
                end
            end
            S_CRASH: begin
                if (SC_GAMESEQ_tick_In) begin
                    hold_d = hold_inc;
                    if (hold_inc == HOLD_END) state_d = (lives_q == '0) ? S_LOSE : S_SPAWN;
                end
            end
            S_NEXT: begin
                if (level_q == LEVEL_MAX) begin
                    state_d = S_WIN;
                end else begin
                    level_d = level_q + 1'b1;
                    state_d = S_SPAWN;
                end
            end
            S_LOSE: begin
                lives_d = '0;
                if (start_press) begin
                    state_d = S_IDLE;
                    lives_d = LIVES_RST;
                    level_d = '0;
                end
            end
            S_WIN: begin
                if (start_press) begin
                    state_d = S_IDLE;
                    lives_d = LIVES_RST;
                    level_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                lives_d = LIVES_RST;
                level_d = '0;
            end
        endcase
    end

    always_comb begin
        SC_GAMESEQ_load_Out     = 1'b0;
        SC_GAMESEQ_run_Out      = 1'b0;
        SC_GAMESEQ_gameover_Out = 1'b0;
        SC_GAMESEQ_win_Out      = 1'b0;
        SC_GAMESEQ_lives_OutBUS = lives_q;
        SC_GAMESEQ_level_OutBUS = level_q;
        SC_GAMESEQ_state_OutBUS = state_q;
        case (state_q)
            S_SPAWN: SC_GAMESEQ_load_Out     = 1'b1;
            S_PLAY:  SC_GAMESEQ_run_Out      = 1'b1;
            S_LOSE:  SC_GAMESEQ_gameover_Out = 1'b1;
            S_WIN:   SC_GAMESEQ_win_Out      = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sc_game_sequencer.sv
// Vector bench for sc_game_sequencer: a table of per-cycle inputs and expected outputs,
// plus hand-written reset-in-the-middle sequences.
module tb_sc_game_sequencer;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SPAWN = 3'd1;
    localparam logic [2:0] PLAY  = 3'd2;
    localparam logic [2:0] CRASH = 3'd3;
    localparam logic [2:0] NEXT  = 3'd4;
    localparam logic [2:0] LOSE  = 3'd5;
    localparam logic [2:0] WIN   = 3'd6;

    logic       clk = 1'b0;
    logic       rst_n, start_n, tick, crash, goal;
    logic       load_o, run_o, go_o, win_o;
    logic [1:0] lives_o, level_o;
    logic [2:0] state_o;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       s, t, c, g;
        logic [2:0] st;
        logic [1:0] lv, lev;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    sc_game_sequencer dut (
        .SC_GAMESEQ_CLOCK_50    (clk),
        .SC_GAMESEQ_RESET_InLow (rst_n),
        .SC_GAMESEQ_start_InLow (start_n),
        .SC_GAMESEQ_tick_In     (tick),
        .SC_GAMESEQ_crash_In    (crash),
        .SC_GAMESEQ_goal_In     (goal),
        .SC_GAMESEQ_load_Out    (load_o),
        .SC_GAMESEQ_run_Out     (run_o),
        .SC_GAMESEQ_lives_OutBUS(lives_o),
        .SC_GAMESEQ_level_OutBUS(level_o),
        .SC_GAMESEQ_gameover_Out(go_o),
        .SC_GAMESEQ_win_Out     (win_o),
        .SC_GAMESEQ_state_OutBUS(state_o)
    );

    task automatic add(input logic s, t, c, g, input logic [2:0] st, input logic [1:0] lv, lev);
        vec_t v;
        v.s = s; v.t = t; v.c = c; v.g = g; v.st = st; v.lv = lv; v.lev = lev;
        vecs.push_back(v);
    endtask

    // Flags are the Moore decode of the expected state.
    task automatic check(input string name, input logic [2:0] st, input logic [1:0] lv, lev);
        logic [10:0] act, exp;
        act = {state_o, lives_o, level_o, load_o, run_o, go_o, win_o};
        exp = {st, lv, lev, st == SPAWN, st == PLAY, st == LOSE, st == WIN};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got st=%0d lives=%0d lvl=%0d load/run/go/win=%b, want st=%0d lives=%0d lvl=%0d load/run/go/win=%b",
                     name, act[10:8], act[7:6], act[5:4], act[3:0], exp[10:8], exp[7:6], exp[5:4], exp[3:0]);
        end
    endtask

    // Drive at the falling edge; one rising edge later, outputs are checked at the next falling edge.
    task automatic step(input logic s, t, c, g);
        start_n = s; tick = t; crash = c; goal = g;
        @(negedge clk);
    endtask

    task automatic run_chk(input string name, input logic s, t, c, g,
                           input logic [2:0] st, input logic [1:0] lv, lev);
        step(s, t, c, g);
        check(name, st, lv, lev);
    endtask

    initial begin
        rst_n = 1'b0; start_n = 1'b1; tick = 1'b0; crash = 1'b0; goal = 1'b0;

        // Start press and button held for ten clocks.
        add(1, 0, 0, 0, IDLE, 3, 0);
        add(0, 0, 0, 0, SPAWN, 3, 0);
        for (int i = 0; i < 9; i++) add(0, 0, 0, 0, PLAY, 3, 0);
        // No tick: crash and goal ignored; then crash wins over goal.
        add(1, 0, 1, 1, PLAY, 3, 0);
        add(1, 1, 1, 1, CRASH, 2, 0);
        add(1, 0, 1, 1, CRASH, 2, 0);
        for (int i = 0; i < 3; i++) add(1, 1, 1, 1, CRASH, 2, 0);
        add(1, 0, 0, 0, CRASH, 2, 0);
        add(1, 1, 0, 0, SPAWN, 2, 0);
        add(1, 0, 0, 0, PLAY, 2, 0);
        add(0, 0, 0, 0, PLAY, 2, 0);
        add(1, 0, 0, 0, PLAY, 2, 0);
        // Level progression up to a win.
        for (int l = 0; l < 3; l++) begin
            add(1, 1, 0, 1, NEXT, 2, 2'(l));
            add(1, 0, 0, 0, SPAWN, 2, 2'(l + 1));
            add(1, 0, 0, 0, PLAY, 2, 2'(l + 1));
        end
        add(1, 1, 0, 1, NEXT, 2, 3);
        add(1, 0, 0, 0, WIN, 2, 3);
        add(1, 0, 0, 0, WIN, 2, 3);
        add(0, 0, 0, 0, IDLE, 3, 0);
        add(0, 0, 0, 0, IDLE, 3, 0);
        add(1, 0, 0, 0, IDLE, 3, 0);
        add(0, 0, 0, 0, SPAWN, 3, 0);
        add(1, 0, 0, 0, PLAY, 3, 0);
        // Three crashes to game over; a press during the last hold is ignored.
        for (int k = 0; k < 3; k++) begin
            add(1, 1, 1, 0, CRASH, 2'(2 - k), 0);
            for (int j = 0; j < 3; j++) add((k == 2 && j == 0) ? 1'b0 : 1'b1, 1, 1, 1, CRASH, 2'(2 - k), 0);
            if (k < 2) begin
                add(1, 1, 0, 0, SPAWN, 2'(2 - k), 0);
                add(1, 0, 0, 0, PLAY, 2'(2 - k), 0);
            end else begin
                add(1, 1, 0, 0, LOSE, 0, 0);
            end
        end
        add(1, 0, 0, 0, LOSE, 0, 0);
        add(0, 0, 0, 0, IDLE, 3, 0);

        @(negedge clk);
        @(negedge clk);
        check("reset_state", IDLE, 3, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].s, vecs[i].t, vecs[i].c, vecs[i].g);
            check($sformatf("vec%0d", i), vecs[i].st, vecs[i].lv, vecs[i].lev);
        end

        // Reset during CRASH with hold count 2, lives 1, level 1.
        run_chk("mr_idle", 1, 0, 0, 0, IDLE, 3, 0);
        run_chk("mr_spawn", 0, 0, 0, 0, SPAWN, 3, 0);
        run_chk("mr_play", 1, 0, 0, 0, PLAY, 3, 0);
        run_chk("mr_next", 1, 1, 0, 1, NEXT, 3, 0);
        run_chk("mr_spawn1", 1, 0, 0, 0, SPAWN, 3, 1);
        run_chk("mr_play1", 1, 0, 0, 0, PLAY, 3, 1);
        run_chk("mr_crash1", 1, 1, 1, 0, CRASH, 2, 1);
        for (int i = 0; i < 3; i++) run_chk("mr_hold1", 1, 1, 0, 0, CRASH, 2, 1);
        run_chk("mr_respawn", 1, 1, 0, 0, SPAWN, 2, 1);
        run_chk("mr_play2", 1, 0, 0, 0, PLAY, 2, 1);
        run_chk("mr_crash2", 1, 1, 1, 0, CRASH, 1, 1);
        run_chk("mr_hold_a", 1, 1, 1, 1, CRASH, 1, 1);
        run_chk("mr_hold_b", 1, 1, 1, 1, CRASH, 1, 1);
        rst_n = 1'b0;
        run_chk("mr_reset_crash", 1, 0, 1, 1, IDLE, 3, 0);
        rst_n = 1'b1;

        // Reset in NEXT discards the pending level increment.
        run_chk("nx_spawn", 0, 0, 0, 0, SPAWN, 3, 0);
        run_chk("nx_play", 1, 0, 0, 0, PLAY, 3, 0);
        run_chk("nx_next", 1, 1, 0, 1, NEXT, 3, 0);
        rst_n = 1'b0;
        run_chk("nx_reset", 1, 0, 0, 0, IDLE, 3, 0);
        rst_n = 1'b1;
        run_chk("nx_after", 1, 0, 0, 0, IDLE, 3, 0);

        // Reset on a crash tick discards the pending lives decrement.
        run_chk("pc_spawn", 0, 0, 0, 0, SPAWN, 3, 0);
        run_chk("pc_play", 1, 0, 0, 0, PLAY, 3, 0);
        rst_n = 1'b0;
        run_chk("pc_reset", 1, 1, 1, 0, IDLE, 3, 0);
        rst_n = 1'b1;
        run_chk("pc_after", 1, 0, 0, 0, IDLE, 3, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sc_game_sequencer.md
Name: sc_game_sequencer

Overview:
- Top-level game-flow controller for the Frogger datapath.
- Consumes the crash flag from the matrix comparator and the goal flag from the frog-position logic, both sampled on the game-step tick.
- Sequences respawn/load of the matrix registers, gates the run enable for road shifting and frog movement, and tracks lives and level.
- Drives the game-over and win indications to the display layer.

Parameters:
- LIVES_INIT, 3, lives loaded at game start; must be 1..2^LIVES_WIDTH-1.
- LIVES_WIDTH, 2, width of the lives counter.
- LEVEL_WIDTH, 2, width of the level counter.
- MAX_LEVEL, 3, last level; clearing it wins the game.
- HOLD_TICKS, 4, ticks spent in CRASH before respawn or lose; must be ≥1.
- HOLD_WIDTH, 3, width of the hold counter; must hold HOLD_TICKS.

Ports:
- SC_GAMESEQ_CLOCK_50  in  1  system clock; all state changes on the rising edge.
- SC_GAMESEQ_RESET_InLow  in  1  synchronous reset, active-low.
- SC_GAMESEQ_start_InLow  in  1  debounced start button, active-low level.
- SC_GAMESEQ_tick_In  in  1  one-clock game-step pulse.
- SC_GAMESEQ_crash_In  in  1  matrix comparator crash flag; 1 = crash.
- SC_GAMESEQ_goal_In  in  1  frog reached top row.
- SC_GAMESEQ_load_Out  out  1  one-clock pulse: reload matrix registers and frog start position.
- SC_GAMESEQ_run_Out  out  1  enable for road shift and frog movement.
- SC_GAMESEQ_lives_OutBUS  out  LIVES_WIDTH  remaining lives.
- SC_GAMESEQ_level_OutBUS  out  LEVEL_WIDTH  current level; also used as speed select.
- SC_GAMESEQ_gameover_Out  out  1  high in LOSE.
- SC_GAMESEQ_win_Out  out  1  high in WIN.
- SC_GAMESEQ_state_OutBUS  out  3  current state code, for debug.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. Reset has priority over all transitions.
- Reset values: state IDLE, lives = LIVES_INIT, level = 0, hold counter = 0, start_prev = 1. All 1-bit outputs 0; state_OutBUS = 0.
- Outputs are Moore-decoded from the registered state.
- State codes: IDLE=0, SPAWN=1, PLAY=2, CRASH=3, NEXT=4, LOSE=5, WIN=6. Codes 7 and above go to IDLE on the next cycle.
- Start press: start_prev==1 and start_InLow==0, one cycle. start_prev is registered every cycle. A held button produces exactly one press.
- IDLE:
  - lives forced to LIVES_INIT, level forced to 0; run=0.
  - Start press → SPAWN.
- SPAWN:
  - load_Out=1 for exactly this one cycle; hold counter cleared.
  - Always → PLAY.
- PLAY:
  - run_Out=1. crash and goal are evaluated only in cycles where tick_In=1.
  - tick & crash → CRASH, lives decremented by 1 (saturating at 0) on the transition edge.
  - tick & !crash & goal → NEXT.
  - Crash has priority over goal in the same tick.
  - Without a tick, crash and goal are ignored (comparator may glitch while the matrix updates).
- CRASH:
  - run=0. The hold counter increments on each tick.
  - On the tick that makes the count equal HOLD_TICKS: lives==0 → LOSE, otherwise → SPAWN.
  - crash and goal are ignored in this state.
- NEXT: one cycle.
  - level==MAX_LEVEL → WIN, level unchanged.
  - Otherwise level+1 → SPAWN.
- LOSE: gameover_Out=1, lives=0. Start press → IDLE.
- WIN: win_Out=1. Start press → IDLE.
- Start presses are ignored in SPAWN, PLAY, CRASH and NEXT.
- Reset mid-game (any state): next cycle is IDLE with reset values. A pending crash decrement or level increment is discarded.
- Latency:
  - Start press → load_Out high: 1 cycle (SPAWN entered on the next edge).
  - Crash tick → run_Out low: 1 cycle.

Test Plan:
- Reset and start: reset low for 2 clocks, release; start_InLow high→low and held 10 clocks → exactly one load_Out pulse, then run_Out=1, lives=3, level=0, state=2.
- Single crash: in PLAY, tick with crash=1 → next cycle state=3, lives=2, run=0. After 4 ticks → load_Out pulse, then PLAY.
- Game over: three crash cycles → after third hold, state=5, gameover=1, lives=0. A start press returns to IDLE with lives=3.
- Level progression and win: four goal ticks with crash=0 → level 0→1→2→3, a load pulse after each of the first three, and the fourth gives state=6, win=1, level=3.
- Tick qualification and priority:
  - crash=1 and goal=1 with tick=0 → no state change.
  - Same with tick=1 → CRASH, not NEXT; level unchanged.
- Mid-operation reset: reset low during CRASH with hold count 2 and lives 1 → state=0, lives=3, level=0, all flags 0. Crash and goal inputs in CRASH are ignored during hold.
